// File: rtl/ysyx_23060096_mem_arb_if.sv
// Signal bundle tying the IFU, the LSU and the shared memory port to the arbiter.
// Handshake: a request transfers on a rising edge where valid && ready are both 1; once raised, valid
// holds with stable fields until that edge and never waits on ready. Responses are single-cycle pulses
// with no ready.
interface ysyx_23060096_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_resp_valid;
    logic [DW-1:0]   ifu_rdata;
    logic            ifu_resp_err;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_wen;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_resp_valid;
    logic [DW-1:0]   lsu_rdata;
    logic            lsu_resp_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_rdata;

    // The arbiter takes the slave view; requesters and memory together form the master view.
    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060096_mem_arb.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight,
// with a watchdog that turns a stalled memory access into an error response.
module ysyx_23060096_mem_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_23060096_mem_arb_if.slave bus,
    output logic                   busy,
    output logic [1:0]             dbg_state
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t          state, state_next;
    logic            owner, last_grant;  // 0 = IFU, 1 = LSU
    logic [AW-1:0]   addr;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   rdata;
    logic            err;
    logic [CW-1:0]   cnt;
    logic            grant_lsu, accept, complete, wd_expire;
    logic            resp_ifu, resp_lsu;

    always_comb begin
        state_next        = state;
        accept            = 1'b0;
        complete          = 1'b0;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        // With both requesters waiting, the one not served last wins.
        if (bus.ifu_req_valid && bus.lsu_req_valid) grant_lsu = !last_grant;
        else                                        grant_lsu = bus.lsu_req_valid;
        wd_expire = (TIMEOUT > 0) && (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (!rst && (bus.ifu_req_valid || bus.lsu_req_valid)) begin
                    accept            = 1'b1;
                    bus.ifu_req_ready = !grant_lsu;
                    bus.lsu_req_ready = grant_lsu;
                    state_next        = REQ;
                end
            end
            REQ: begin
                complete = bus.mem_req_ready;
                if (complete)       state_next = WAIT;
                else if (wd_expire) state_next = RESP;
            end
            WAIT: begin
                complete = bus.mem_resp_valid;
                if (complete || wd_expire) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            addr       <= '0;
            wen        <= 1'b0;
            wdata      <= '0;
            wmask      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant_lsu;
                        last_grant <= grant_lsu;
                        addr       <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                        wen        <= grant_lsu && bus.lsu_wen;
                        wdata      <= grant_lsu ? bus.lsu_wdata : '0;
                        wmask      <= grant_lsu ? bus.lsu_wmask : '0;
                        cnt        <= '0;
                    end
                end
                REQ, WAIT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    // A completion in the expiry cycle takes the normal path.
                    if (state == WAIT && complete) begin
                        rdata <= bus.mem_rdata;
                        err   <= 1'b0;
                    end else if (!complete && wd_expire) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_ifu = (state == RESP) && !owner;
    assign resp_lsu = (state == RESP) && owner;

    assign bus.mem_req_valid  = (state == REQ);
    assign bus.mem_addr       = addr;
    assign bus.mem_wen        = wen;
    assign bus.mem_wdata      = wdata;
    assign bus.mem_wmask      = wmask;
    assign bus.ifu_resp_valid = resp_ifu;
    assign bus.ifu_rdata      = resp_ifu ? rdata : '0;
    assign bus.ifu_resp_err   = resp_ifu && err;
    assign bus.lsu_resp_valid = resp_lsu;
    assign bus.lsu_rdata      = resp_lsu ? rdata : '0;
    assign bus.lsu_resp_err   = resp_lsu && err;
    assign busy               = (state != IDLE);
    assign dbg_state          = state;
endmodule

// File: tb/tb_ysyx_23060096_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter: a transaction-level model checks every cycle,
// and each scenario pins its key cycles with literal values.
module tb_ysyx_23060096_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int W  = DW + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    ysyx_23060096_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    ysyx_23060096_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // transaction-level model: one record per accepted request, timed from its accept cycle
    logic [W-1:0]    exp_q[$];
    bit              m_act, m_last, m_own, m_issued, m_done, g;
    logic [AW-1:0]   m_addr;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wmask;
    int              m_tacc, age;
    bit              e_busy, e_ir, e_lr, e_mrv, e_iresp, e_lresp;
    logic [W-1:0]    e_resp;

    always @(negedge clk) begin
        if (rst) begin
            m_act  = 1'b0;
            m_last = 1'b0;
            exp_q.delete();
        end else begin
            e_busy = m_act; e_ir = 0; e_lr = 0; e_mrv = 0; e_iresp = 0; e_lresp = 0;
            if (!m_act) begin
                if (bus.ifu_req_valid || bus.lsu_req_valid) begin
                    g = (bus.ifu_req_valid && bus.lsu_req_valid) ? !m_last : bus.lsu_req_valid;
                    e_ir = !g; e_lr = g;
                    m_act = 1; m_own = g; m_last = g; m_issued = 0; m_done = 0; m_tacc = cyc;
                    m_addr  = g ? bus.lsu_addr : bus.ifu_addr;
                    m_wen   = g && bus.lsu_wen;
                    m_wdata = g ? bus.lsu_wdata : '0;
                    m_wmask = g ? bus.lsu_wmask : '0;
                end
            end else if (m_done) begin
                e_iresp = !m_own; e_lresp = m_own;
                m_act = 0;
            end else begin
                age = cyc - m_tacc;
                if (!m_issued) begin
                    e_mrv = 1;
                    chk("mem_addr", bus.mem_addr, m_addr);
                    chk("mem_wen", bus.mem_wen, m_wen);
                    chk("mem_wdata", bus.mem_wdata, m_wdata);
                    chk("mem_wmask", bus.mem_wmask, m_wmask);
                    if (bus.mem_req_ready) m_issued = 1;
                    else if (age == TO) begin
                        m_done = 1; exp_q.push_back({m_own, 1'b1, {DW{1'b0}}});
                    end
                end else if (bus.mem_resp_valid) begin
                    m_done = 1; exp_q.push_back({m_own, 1'b0, bus.mem_rdata});
                end else if (age == TO) begin
                    m_done = 1; exp_q.push_back({m_own, 1'b1, {DW{1'b0}}});
                end
            end
            chk("busy", busy, e_busy);
            chk("ifu_req_ready", bus.ifu_req_ready, e_ir);
            chk("lsu_req_ready", bus.lsu_req_ready, e_lr);
            chk("mem_req_valid", bus.mem_req_valid, e_mrv);
            chk("ifu_resp_valid", bus.ifu_resp_valid, e_iresp);
            chk("lsu_resp_valid", bus.lsu_resp_valid, e_lresp);
            if (e_iresp || e_lresp) begin
                if (exp_q.size() == 0) chk("resp_queue_empty", 1, 0);
                else begin
                    e_resp = exp_q.pop_front();
                    if (e_lresp) begin
                        chk("lsu_rdata", bus.lsu_rdata, e_resp[DW-1:0]);
                        chk("lsu_resp_err", bus.lsu_resp_err, e_resp[DW]);
                        chk("ifu_rdata_idle", bus.ifu_rdata, 0);
                    end else begin
                        chk("ifu_rdata", bus.ifu_rdata, e_resp[DW-1:0]);
                        chk("ifu_resp_err", bus.ifu_resp_err, e_resp[DW]);
                        chk("lsu_rdata_idle", bus.lsu_rdata, 0);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    bit glog[$];
    int gcyc[$];

    task automatic auto_run(input int n);
        bit hs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.ifu_req_valid && bus.ifu_req_ready) begin glog.push_back(1'b0); gcyc.push_back(cyc); end
            if (bus.lsu_req_valid && bus.lsu_req_ready) begin glog.push_back(1'b1); gcyc.push_back(cyc); end
            hs = bus.mem_req_valid && bus.mem_req_ready;
            tick();
            bus.mem_resp_valid = hs;
            bus.mem_rdata      = 32'hA500_0000 | 32'(cyc);
        end
    endtask

    bit exp_g[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        bus.ifu_req_valid = 0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 0; bus.lsu_addr = '0; bus.lsu_wen = 0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
        chk("rst_lsu_resp_valid", bus.lsu_resp_valid, 0);

        // 1: IFU fetch, no stalls
        tick();
        bus.mem_req_ready = 1; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0000;
        @(negedge clk); chk("t1_ifu_ready", bus.ifu_req_ready, 1);
        tick(); bus.ifu_req_valid = 0;
        @(negedge clk);
        chk("t1_mem_req_valid", bus.mem_req_valid, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
        chk("t1_mem_wen", bus.mem_wen, 0);
        tick(); bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0010_0093;
        tick(); bus.mem_resp_valid = 0;
        @(negedge clk);
        chk("t1_ifu_resp_valid", bus.ifu_resp_valid, 1);
        chk("t1_ifu_rdata", bus.ifu_rdata, 32'h0010_0093);
        chk("t1_ifu_err", bus.ifu_resp_err, 0);
        tick();
        @(negedge clk); chk("t1_busy_done", busy, 0);

        // 2: both requesters held valid after reset
        do_reset();
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0100;
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_3000; bus.lsu_wen = 0;
        bus.mem_req_ready = 1;
        auto_run(13);
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        auto_run(5);
        bus.mem_resp_valid = 0;
        chk("t2_grant_count", glog.size(), 4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), glog[i], exp_g[i]);
            chk("t2_grant_spacing1", gcyc[1] - gcyc[0], 4);
            chk("t2_grant_spacing2", gcyc[2] - gcyc[1], 4);
        end

        // 3: LSU write with memory not ready for 3 cycles
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_1000; bus.lsu_wen = 1;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'b0011; bus.mem_req_ready = 0;
        tick(); bus.lsu_req_valid = 0; bus.lsu_wen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_mem_req_valid", bus.mem_req_valid, 1);
            chk("t3_mem_addr", bus.mem_addr, 32'h8000_1000);
            chk("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("t3_mem_wmask", bus.mem_wmask, 4'b0011);
            chk("t3_mem_wen", bus.mem_wen, 1);
            tick();
        end
        bus.mem_req_ready = 1;
        @(negedge clk); chk("t3_valid_held", bus.mem_req_valid, 1);
        tick(); bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0;
        tick(); bus.mem_resp_valid = 0;
        @(negedge clk);
        chk("t3_lsu_resp_valid", bus.lsu_resp_valid, 1);
        chk("t3_lsu_err", bus.lsu_resp_err, 0);
        tick();

        // 4: memory never responds -> watchdog error in WAIT
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_2000;
        tick(); bus.lsu_req_valid = 0;
        repeat (7) tick();
        @(negedge clk);
        chk("t4_no_resp_yet", bus.lsu_resp_valid, 0);
        chk("t4_req_dropped", bus.mem_req_valid, 0);
        tick();
        @(negedge clk);
        chk("t4_lsu_resp_valid", bus.lsu_resp_valid, 1);
        chk("t4_lsu_err", bus.lsu_resp_err, 1);
        chk("t4_lsu_rdata", bus.lsu_rdata, 0);
        tick();
        @(negedge clk); chk("t4_busy_done", busy, 0);

        // 4b: memory never ready -> watchdog error in REQ
        bus.mem_req_ready = 0; bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0040;
        tick(); bus.ifu_req_valid = 0;
        repeat (7) tick();
        @(negedge clk); chk("t4b_valid_held", bus.mem_req_valid, 1);
        tick();
        @(negedge clk);
        chk("t4b_ifu_resp_valid", bus.ifu_resp_valid, 1);
        chk("t4b_ifu_err", bus.ifu_resp_err, 1);
        chk("t4b_req_dropped", bus.mem_req_valid, 0);
        tick(); bus.mem_req_ready = 1;

        // 5: reset while waiting for memory
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_4000;
        tick(); bus.ifu_req_valid = 0;
        tick(); rst = 1;
        tick(); rst = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_no_ifu_resp", bus.ifu_resp_valid, 0);
        tick(); bus.mem_resp_valid = 0;
        @(negedge clk);
        chk("t5_late_resp_ignored", bus.ifu_resp_valid, 0);
        chk("t5_still_idle", busy, 0);
        tick();

        // 6: completion in the watchdog's last cycle wins
        bus.lsu_req_valid = 1; bus.lsu_addr = 32'h8000_5000;
        tick(); bus.lsu_req_valid = 0;
        repeat (7) tick();
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h1234_5678;
        @(negedge clk); chk("t6_busy", busy, 1);
        tick(); bus.mem_resp_valid = 0;
        @(negedge clk);
        chk("t6_lsu_resp_valid", bus.lsu_resp_valid, 1);
        chk("t6_lsu_err", bus.lsu_resp_err, 0);
        chk("t6_lsu_rdata", bus.lsu_rdata, 32'h1234_5678);
        tick();
        @(negedge clk); chk("t6_busy_done", busy, 0);

        tick();
        tick();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
